// File: rtl/flag_stack_register.sv
// flag_stack_register: condition flags with per-bit write enables, sticky bits and a LIFO save/restore stack.
// Optional FLAG_STACK_BYPASS_EN adds flag_fwd_o, a combinational copy of the next flag state.
module flag_stack_register #(
    parameter int                 WIDTH       = 3,
    parameter int                 DEPTH       = 4,
    parameter logic [WIDTH-1:0]   STICKY_MASK = '0,
    localparam int                CW          = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] flag_new_i,
    input  logic [WIDTH-1:0] wen_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             err_clr_i,
    output logic [WIDTH-1:0] flag_current_o,
    output logic [CW-1:0]    depth_count_o,
    output logic             full_o,
    output logic             empty_o,
`ifdef FLAG_STACK_BYPASS_EN
    output logic [WIDTH-1:0] flag_fwd_o,
`endif
    output logic             stack_err_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] stack_q [2**AW];
    logic [WIDTH-1:0] flags_q, flags_d, base;
    logic [CW-1:0]    depth_q, depth_d;
    logic             err_q, err_d;
    logic             push_ok, pop_ok, err_set;

    assign full_o         = depth_q == CW'(DEPTH);
    assign empty_o        = depth_q == '0;
    assign flag_current_o = flags_q;
    assign depth_count_o  = depth_q;
    assign stack_err_o    = err_q;
`ifdef FLAG_STACK_BYPASS_EN
    assign flag_fwd_o     = rst_n ? flags_d : '0;
`endif

    // Next-state: stack acceptance, restore base, per-bit write/sticky merge, error latch
    always_comb begin
        push_ok = push_i && !pop_i && !full_o;
        pop_ok  = pop_i && !push_i && !empty_o;
        err_set = (push_i && pop_i) || (push_i && full_o) || (pop_i && empty_o);
        base    = pop_ok ? stack_q[AW'(depth_q - CW'(1))] : flags_q;
        flags_d = (~wen_i & base) | (wen_i & ~STICKY_MASK & flag_new_i)
                | (wen_i & STICKY_MASK & (base | flag_new_i));
        depth_d = push_ok ? depth_q + CW'(1) : pop_ok ? depth_q - CW'(1) : depth_q;
        err_d   = err_set ? 1'b1 : err_clr_i ? 1'b0 : err_q;
    end

    // Flag, depth and error registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= '0;
            depth_q <= '0;
            err_q   <= 1'b0;
        end else begin
            flags_q <= flags_d;
            depth_q <= depth_d;
            err_q   <= err_d;
        end
    end

    // Stack storage; contents are unobservable until pushed, so no reset
    always_ff @(posedge clk) begin
        if (push_ok) stack_q[AW'(depth_q)] <= flags_q;
    end
endmodule

// File: tb/tb_flag_stack_register.sv
// tb_flag_stack_register: directed checks of flag_stack_register (default, sticky and DEPTH=1 builds).
module tb_flag_stack_register;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] flag_new = '0, wen = '0;
    logic       push = 1'b0, pop = 1'b0, err_clr = 1'b0;
    logic [2:0] fc_a, fc_s, fc_1, fw_a, fw_s, fw_1;
    logic [2:0] dc_a, dc_s;
    logic [0:0] dc_1;
    logic       fu_a, fu_s, fu_1, em_a, em_s, em_1, er_a, er_s, er_1;
    int         n_tests = 0, n_fail = 0;

    always #5 clk = ~clk;

    flag_stack_register u_dut (
        .clk(clk), .rst_n(rst_n), .flag_new_i(flag_new), .wen_i(wen), .push_i(push), .pop_i(pop),
        .err_clr_i(err_clr), .flag_current_o(fc_a), .depth_count_o(dc_a), .full_o(fu_a),
        .empty_o(em_a),
`ifdef FLAG_STACK_BYPASS_EN
        .flag_fwd_o(fw_a),
`endif
        .stack_err_o(er_a)
    );

    flag_stack_register #(.STICKY_MASK(3'b010)) u_stk (
        .clk(clk), .rst_n(rst_n), .flag_new_i(flag_new), .wen_i(wen), .push_i(push), .pop_i(pop),
        .err_clr_i(err_clr), .flag_current_o(fc_s), .depth_count_o(dc_s), .full_o(fu_s),
        .empty_o(em_s),
`ifdef FLAG_STACK_BYPASS_EN
        .flag_fwd_o(fw_s),
`endif
        .stack_err_o(er_s)
    );

    flag_stack_register #(.DEPTH(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .flag_new_i(flag_new), .wen_i(wen), .push_i(push), .pop_i(pop),
        .err_clr_i(err_clr), .flag_current_o(fc_1), .depth_count_o(dc_1), .full_o(fu_1),
        .empty_o(em_1),
`ifdef FLAG_STACK_BYPASS_EN
        .flag_fwd_o(fw_1),
`endif
        .stack_err_o(er_1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic [2:0] n, input logic [2:0] w, input logic pu, input logic po,
                       input logic cl);
        logic [2:0] pa, ps;
        flag_new = n; wen = w; push = pu; pop = po; err_clr = cl;
        #3;
        pa = fw_a; ps = fw_s;
        @(posedge clk);
        #1;
        flag_new = '0; wen = '0; push = 1'b0; pop = 1'b0; err_clr = 1'b0;
`ifdef FLAG_STACK_BYPASS_EN
        check("fwd_a", pa, fc_a);
        check("fwd_s", ps, fc_s);
`else
        pa = '0; ps = '0;
`endif
    endtask

    initial begin
        #1;
        check("rst_flag", fc_a, 3'b000);
        check("rst_depth", dc_a, 0);
        check("rst_empty", em_a, 1);
        check("rst_full", fu_a, 0);
        check("rst_err", er_a, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        // per-bit write
        cyc(3'b111, 3'b101, 0, 0, 0);
        check("wr_bits", fc_a, 3'b101);
        // push/pop round trip
        cyc(3'b110, 3'b111, 0, 0, 0);
        check("rt_set", fc_a, 3'b110);
        cyc(3'b000, 3'b000, 1, 0, 0);
        check("rt_push_depth", dc_a, 1);
        check("d1_full", fu_1, 1);
        check("d1_depth", dc_1, 1);
        cyc(3'b001, 3'b111, 0, 0, 0);
        check("rt_write", fc_a, 3'b001);
        cyc(3'b000, 3'b000, 0, 1, 0);
        check("rt_pop_flag", fc_a, 3'b110);
        check("rt_pop_depth", dc_a, 0);
        check("rt_pop_empty", em_a, 1);
        // overflow: entries 110,001,010,011 then a rejected 5th push
        for (int i = 1; i <= 4; i++) cyc(3'(i), 3'b111, 1, 0, 0);
        check("ov_depth4", dc_a, 4);
        check("ov_full4", fu_a, 1);
        check("ov_err4", er_a, 0);
        cyc(3'b101, 3'b111, 1, 0, 0);
        check("ov_depth5", dc_a, 4);
        check("ov_err5", er_a, 1);
        check("ov_flag5", fc_a, 3'b101);
        cyc(3'b000, 3'b000, 0, 0, 1);
        check("ov_clr", er_a, 0);
        cyc(3'b000, 3'b000, 0, 1, 0);
        check("pop3", fc_a, 3'b011);
        cyc(3'b000, 3'b000, 0, 1, 0);
        check("pop2", fc_a, 3'b010);
        cyc(3'b000, 3'b000, 0, 1, 0);
        check("pop1", fc_a, 3'b001);
        cyc(3'b000, 3'b000, 0, 1, 0);
        check("pop0", fc_a, 3'b110);
        check("pop0_depth", dc_a, 0);
        cyc(3'b000, 3'b000, 0, 1, 0);
        check("un_err", er_a, 1);
        check("un_flag", fc_a, 3'b110);
        check("un_depth", dc_a, 0);
        // conflict at depth 2, set wins over clear
        cyc(3'b000, 3'b000, 0, 0, 1);
        check("cf_clr", er_a, 0);
        cyc(3'b000, 3'b000, 1, 0, 0);
        cyc(3'b000, 3'b000, 1, 0, 0);
        check("cf_depth_pre", dc_a, 2);
        cyc(3'b111, 3'b001, 1, 1, 1);
        check("cf_depth", dc_a, 2);
        check("cf_err", er_a, 1);
        check("cf_flag", fc_a, 3'b111);
        // asynchronous reset mid-run
        rst_n = 1'b0;
        #1;
        check("ar_flag", fc_a, 3'b000);
        check("ar_depth", dc_a, 0);
        check("ar_empty", em_a, 1);
        check("ar_err", er_a, 0);
`ifdef FLAG_STACK_BYPASS_EN
        check("ar_fwd", fw_a, 3'b000);
`endif
        #1 rst_n = 1'b1;
        // sticky bit 1
        cyc(3'b010, 3'b010, 0, 0, 0);
        check("st_set", fc_s, 3'b010);
        cyc(3'b000, 3'b010, 0, 0, 0);
        check("st_hold", fc_s, 3'b010);
        check("nm_clear", fc_a, 3'b000);
        cyc(3'b110, 3'b111, 0, 0, 0);
        check("st_w110", fc_s, 3'b110);
        cyc(3'b000, 3'b000, 1, 0, 0);
        cyc(3'b001, 3'b101, 0, 0, 0);
        check("st_w001", fc_s, 3'b011);
        cyc(3'b001, 3'b111, 0, 1, 0);
        check("st_pop_a", fc_s, 3'b011);
        cyc(3'b000, 3'b000, 1, 0, 0);
        cyc(3'b101, 3'b111, 0, 1, 0);
        check("st_pop_b", fc_s, 3'b111);
        check("st_depth", dc_s, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/flag_stack_register.md
Name: flag_stack_register

Overview:
Parametrised condition-flag register with per-bit write enables, optional sticky (accumulating) bits, and a LIFO save/restore stack.
Sits beside the ALU in the execute stage. The ALU writes flags; branch logic reads flag_current.
Push/pop save and restore the flag context around calls and interrupts, replacing the earlier fixed 3-bit register.

Parameters:
WIDTH, 3, number of flag bits (bit 0 = Z, bit 1 = V, bit 2 = N at default).
DEPTH, 4, number of save-stack entries (>= 1).
STICKY_MASK, {WIDTH{1'b0}}, per-bit; 1 = sticky bit (write ORs into current value), 0 = normal overwrite.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  asynchronous, active-low reset.
flag_new  input  WIDTH  candidate flag values from the ALU.
wen  input  WIDTH  per-bit write enable for flag_new.
push  input  1  save flag_current onto the stack.
pop  input  1  restore flags from the stack top.
err_clr  input  1  clears stack_err.
flag_current  output  WIDTH  registered flag state.
depth_count  output  $clog2(DEPTH+1)  number of valid stack entries.
full  output  1  depth_count == DEPTH.
empty  output  1  depth_count == 0.
stack_err  output  1  sticky overflow/underflow/conflict indicator.

Behaviour:
- Reset (rst low, asynchronous; held for any cycle count):
  - flag_current = 0, depth_count = 0, empty = 1, full = 0, stack_err = 0.
  - Stack contents are don't-care and are never observable.
- All state updates occur on the rising clk edge. flag_current reflects the update one cycle after the inputs are sampled.
- Base value B, per bit:
  - If pop is accepted, B = the stack top entry.
  - Otherwise B = the current flag_current.
- Next value, per bit i:
  - wen[i] = 0: B[i].
  - wen[i] = 1 and STICKY_MASK[i] = 0: flag_new[i].
  - wen[i] = 1 and STICKY_MASK[i] = 1: B[i] | flag_new[i].
  - Consequences: wen overrides restore on normal bits; on sticky bits, restore and new value are ORed.
- Push accepted (push = 1, pop = 0, not full):
  - The pre-update flag_current is written to entry depth_count.
  - depth_count increments.
  - wen writes still apply to flag_current in the same cycle.
- Pop accepted (pop = 1, push = 0, not empty):
  - depth_count decrements.
  - The entry at depth_count-1 becomes B.
- Push when full:
  - Stack and depth_count are unchanged; stack_err is set.
  - Flag writes via wen still occur.
- Pop when empty:
  - No stack change and no restore (B = flag_current); stack_err is set.
  - Flag writes via wen still occur.
- push and pop in the same cycle:
  - Illegal. No stack movement, no restore; stack_err is set.
  - wen writes apply normally.
- stack_err:
  - Set has priority over err_clr in the same cycle.
  - Otherwise cleared by err_clr; holds until cleared or reset.
- full and empty are decoded combinationally from registered depth_count; they are never both 1.
- DEPTH = 1 is legal: a single push makes the stack full.

Optional Feature:
FLAG_STACK_BYPASS_EN
- Defined: adds output flag_fwd [WIDTH], a combinational copy of the next-state value of flag_current computed above.
  - Lets the decode-stage branch unit use flags in the same cycle the ALU produces them.
  - flag_fwd = 0 while rst is low.
- Undefined: flag_fwd port is absent; consumers see flags only via registered flag_current (1-cycle latency).

Test Plan:
- Reset: drive rst low mid-run with depth_count = 2 -> flag_current = 3'b000, depth_count = 0, empty = 1, stack_err = 0 immediately (asynchronous), no clock edge required.
- Per-bit write: flag_current = 3'b000; flag_new = 3'b111, wen = 3'b101 -> next cycle flag_current = 3'b101.
- Push/pop round-trip:
  - flags 3'b110; push -> depth_count = 1.
  - Write 3'b001 with wen = 3'b111 -> flag_current = 3'b001.
  - pop -> flag_current = 3'b110, depth_count = 0, empty = 1.
- Overflow/underflow (DEPTH = 4):
  - 5 pushes -> depth_count = 4, full = 1, stack_err = 1 after the 5th push; stack contents unchanged.
  - err_clr -> stack_err = 0.
  - Pop on empty -> stack_err = 1, flags unchanged.
- Restore vs write, STICKY_MASK = 3'b010:
  - Stack top = 3'b010, flag_current = 3'b000.
  - pop with flag_new = 3'b101, wen = 3'b111 -> flag_current = 3'b111 (bits 0 and 2 from write, bit 1 = restore OR new).
- Conflict: push = pop = 1 with depth_count = 2 -> depth_count stays 2, stack_err = 1. With FLAG_STACK_BYPASS_EN defined, flag_fwd equals flag_current one cycle later for every scenario above.
